// File: rtl/mealy_overlap_11010_pkg.sv
// Shared types and constants for the 11010 overlapping Mealy pattern detector.
// Reference models elsewhere pick up PATTERN from here rather than hard-coding it.
package mealy_overlap_11010_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_1    = 3'd1,
    S_11   = 3'd2,
    S_110  = 3'd3,
    S_1101 = 3'd4
  } state_e;

  localparam logic [4:0] PATTERN     = 5'b11010;
  localparam int         PATTERN_LEN = 5;

endpackage

// File: rtl/mealy_overlap_11010.sv
// Serial Mealy detector for 1,1,0,1,0 with overlap; data_out is a combinational
// single-cycle strobe raised while the final 0 is present on data_in.
module mealy_overlap_11010
  import mealy_overlap_11010_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic data_in,
  output logic data_out
);

  state_e state_q;
  state_e state_d;
  logic   match_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // State names are the matched prefix; S_1101 on a 1 falls back to the reusable "11".
  always_comb begin
    state_d = S_IDLE;
    match_d = 1'b0;
    case (state_q)
      S_IDLE: state_d = data_in ? S_1 : S_IDLE;
      S_1:    state_d = data_in ? S_11 : S_IDLE;
      S_11:   state_d = data_in ? S_11 : S_110;
      S_110:  state_d = data_in ? S_1101 : S_IDLE;
      S_1101: begin
        state_d = data_in ? S_11 : S_IDLE;
        match_d = ~data_in;
      end
      default: begin
        state_d = S_IDLE;
        match_d = 1'b0;
      end
    endcase
  end

  assign data_out = match_d & rst;

endmodule

// File: tb/tb_mealy_overlap_11010.sv
// Scoreboard bench for the 11010 Mealy detector: expectations are queued as bits
// are driven and popped when data_out is sampled mid-cycle.
module tb_mealy_overlap_11010;
  import mealy_overlap_11010_pkg::*;

  logic clk;
  logic rst;
  logic data_in;
  logic data_out;

  int n_vec;
  int n_bad;
  bit exp_q[$];
  bit exp_v;

  logic [3:0] mdl_hist;
  int         mdl_len;

  mealy_overlap_11010 dut (
    .clk      (clk),
    .rst      (rst),
    .data_in  (data_in),
    .data_out (data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no summary, required summary");
    $fatal(1, "watchdog");
  end

  task automatic reset_dut();
    @(negedge clk);
    rst = 1'b0;
    data_in = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    mdl_hist = 4'd0;
    mdl_len = 0;
  endtask

  task automatic drive_bit(input bit b, input bit e);
    @(negedge clk);
    data_in = b;
    exp_q.push_back(e);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    data_in = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      data_in = i[0];
      exp_q.push_back(1'b0);
      #2;
      exp_v = exp_q.pop_front();
      n_vec++;
      if (data_out !== exp_v) begin
        n_bad++;
        $display("FAIL reset_hold[%0d]: data_out=%b required=%b", i, data_out, exp_v);
      end
    end
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive_bit(PATTERN[4-i], 1'b0);
      #2;
      exp_v = exp_q.pop_front();
      n_vec++;
      if (data_out !== exp_v) begin
        n_bad++;
        $display("FAIL reset_release_prefix[%0d]: data_out=%b required=%b", i, data_out, exp_v);
      end
    end
    drive_bit(1'b0, 1'b1);
    #1;
    exp_v = exp_q.pop_front();
    n_vec++;
    if (data_out !== exp_v) begin
      n_bad++;
      $display("FAIL reset_release_match: data_out=%b required=%b", data_out, exp_v);
    end
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      data_in = ~i[0];
      exp_q.push_back(1'b0);
      #1;
      exp_v = exp_q.pop_front();
      n_vec++;
      if (data_out !== exp_v) begin
        n_bad++;
        $display("FAIL reset_forces_zero[%0d]: data_out=%b required=%b", i, data_out, exp_v);
      end
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_basic_overlap();
    bit stim [11] = '{1,1,0,1,0,1,1,0,1,0,1};
    bit expv [11] = '{0,0,0,0,1,0,0,0,0,1,0};
    reset_dut();
    for (int i = 0; i < 11; i++) begin
      drive_bit(stim[i], expv[i]);
      #2;
      exp_v = exp_q.pop_front();
      n_vec++;
      if (data_out !== exp_v) begin
        n_bad++;
        $display("FAIL basic_overlap[%0d]: data_out=%b required=%b", i, data_out, exp_v);
      end
    end
  endtask

  task automatic test_run_of_ones();
    bit stim [7] = '{1,1,1,1,0,1,0};
    bit expv [7] = '{0,0,0,0,0,0,1};
    reset_dut();
    for (int i = 0; i < 7; i++) begin
      drive_bit(stim[i], expv[i]);
      #2;
      exp_v = exp_q.pop_front();
      n_vec++;
      if (data_out !== exp_v) begin
        n_bad++;
        $display("FAIL run_of_ones[%0d]: data_out=%b required=%b", i, data_out, exp_v);
      end
    end
  endtask

  task automatic test_near_miss();
    bit stim [8] = '{1,1,0,1,1,0,1,0};
    bit expv [8] = '{0,0,0,0,0,0,0,1};
    reset_dut();
    for (int i = 0; i < 8; i++) begin
      drive_bit(stim[i], expv[i]);
      #2;
      exp_v = exp_q.pop_front();
      n_vec++;
      if (data_out !== exp_v) begin
        n_bad++;
        $display("FAIL near_miss[%0d]: data_out=%b required=%b", i, data_out, exp_v);
      end
    end
  endtask

  task automatic test_async_reset();
    bit stim [4] = '{1,1,0,1};
    reset_dut();
    for (int i = 0; i < 4; i++) begin
      drive_bit(stim[i], 1'b0);
      #2;
      exp_v = exp_q.pop_front();
      n_vec++;
      if (data_out !== exp_v) begin
        n_bad++;
        $display("FAIL async_prefix[%0d]: data_out=%b required=%b", i, data_out, exp_v);
      end
    end
    drive_bit(1'b0, 1'b1);
    #1;
    exp_v = exp_q.pop_front();
    n_vec++;
    if (data_out !== exp_v) begin
      n_bad++;
      $display("FAIL async_pre_reset: data_out=%b required=%b", data_out, exp_v);
    end
    rst = 1'b0;
    exp_q.push_back(1'b0);
    #1;
    exp_v = exp_q.pop_front();
    n_vec++;
    if (data_out !== exp_v) begin
      n_bad++;
      $display("FAIL async_drop: data_out=%b required=%b", data_out, exp_v);
    end
    rst = 1'b1;
    exp_q.push_back(1'b0);
    #1;
    exp_v = exp_q.pop_front();
    n_vec++;
    if (data_out !== exp_v) begin
      n_bad++;
      $display("FAIL async_trailing_zero: data_out=%b required=%b", data_out, exp_v);
    end
    drive_bit(1'b0, 1'b0);
    #2;
    exp_v = exp_q.pop_front();
    n_vec++;
    if (data_out !== exp_v) begin
      n_bad++;
      $display("FAIL async_after_release: data_out=%b required=%b", data_out, exp_v);
    end
  endtask

  task automatic test_mealy_timing();
    bit stim [4] = '{1,1,0,1};
    bit tog  [3] = '{0,1,0};
    reset_dut();
    for (int i = 0; i < 4; i++) begin
      drive_bit(stim[i], 1'b0);
      #2;
      exp_v = exp_q.pop_front();
      n_vec++;
      if (data_out !== exp_v) begin
        n_bad++;
        $display("FAIL mealy_prefix[%0d]: data_out=%b required=%b", i, data_out, exp_v);
      end
    end
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      data_in = tog[i];
      exp_q.push_back(~tog[i]);
      #1;
      exp_v = exp_q.pop_front();
      n_vec++;
      if (data_out !== exp_v) begin
        n_bad++;
        $display("FAIL mealy_toggle[%0d]: data_out=%b required=%b", i, data_out, exp_v);
      end
    end
  endtask

  task automatic test_random_stream();
    bit b;
    bit e;
    reset_dut();
    for (int i = 0; i < 300; i++) begin
      b = bit'($urandom_range(0, 1));
      e = (mdl_len >= PATTERN_LEN - 1) && ({mdl_hist, b} == PATTERN);
      drive_bit(b, e);
      mdl_hist = {mdl_hist[2:0], b};
      mdl_len++;
      #2;
      exp_v = exp_q.pop_front();
      n_vec++;
      if (data_out !== exp_v) begin
        n_bad++;
        $display("FAIL random[%0d]: data_out=%b required=%b", i, data_out, exp_v);
      end
    end
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    rst = 1'b0;
    data_in = 1'b0;
    mdl_hist = 4'd0;
    mdl_len = 0;
    test_reset();
    test_basic_overlap();
    test_run_of_ones();
    test_near_miss();
    test_async_reset();
    test_mealy_timing();
    test_random_stream();
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: leftover=%0d required=0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
